// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice.
// It accepts a W-bit command, steps the slice LSB first for W cycles,
// and returns the result with its carry and zero flags.
module bit_serial_alu_ctrl #(
  parameter int unsigned W             = 8,
  parameter int unsigned FUNCTION_BITS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [2:0]               I_op,
  input  logic [W-1:0]             I_a,
  input  logic [W-1:0]             I_b,
  output logic [FUNCTION_BITS-1:0] O_alu_sel,
  output logic                     o_alu_a,
  output logic                     o_alu_b,
  output logic                     o_alu_c,
  input  logic                     i_alu_s,
  input  logic                     i_alu_c,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [W-1:0]             O_result,
  output logic                     o_carry,
  output logic                     o_zero
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic                     w_accept;
  logic                     w_last;
  logic [2:0]               r_op;
  logic [W-1:0]             r_a;
  logic [W-1:0]             r_b;
  logic [W-1:0]             r_result;
  logic [W-1:0]             w_result_nxt;
  logic [CW-1:0]            r_cnt;
  logic                     r_carry;
  logic                     r_cout;
  logic                     r_zero;
  logic                     r_valid;
  logic                     r_ready;
  logic [FUNCTION_BITS-1:0] r_sel;

  // Slice function select for a given opcode; bit 0 differs only for arithmetic ops.
  function automatic logic [FUNCTION_BITS-1:0] sel_for(input logic [2:0] op, input logic first);
    logic [3:0] s;
    case (op)
      OP_ADD:  s = first ? 4'b0000 : 4'b0100;
      OP_SUB:  s = first ? 4'b0011 : 4'b0101;
      OP_INC:  s = first ? 4'b0010 : 4'b0100;
      OP_DEC:  s = first ? 4'b0001 : 4'b0101;
      OP_AND:  s = 4'b1000;
      OP_OR:   s = 4'b1010;
      OP_XOR:  s = 4'b0000;
      default: s = 4'b0001;
    endcase
    return FUNCTION_BITS'(s);
  endfunction

  assign w_result_nxt = {i_alu_s, r_result[W-1:1]};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE accepts, RUN counts W bits, DONE waits for the consumer.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid && r_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(W - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand shifters, slice drive, result collection and flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= 3'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b1;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
      r_sel    <= '0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_op    <= I_op;
        r_a     <= I_a;
        // INC/DEC run the adder against a zero B operand.
        r_b     <= (I_op == OP_INC || I_op == OP_DEC) ? '0 : I_b;
        r_cnt   <= '0;
        r_carry <= 1'b0;
        r_sel   <= sel_for(I_op, 1'b1);
      end else if (r_state == S_RUN) begin
        // Zero fill leaves the slice operand bits at 0 once the op is finished.
        r_a      <= {1'b0, r_a[W-1:1]};
        r_b      <= {1'b0, r_b[W-1:1]};
        r_result <= w_result_nxt;
        if (w_last) begin
          r_cnt   <= '0;
          r_carry <= 1'b0;
          r_sel   <= '0;
          r_cout  <= r_op[2] ? 1'b0 : i_alu_c;
          r_zero  <= (w_result_nxt == '0);
        end else begin
          r_cnt   <= r_cnt + CW'(1);
          r_carry <= i_alu_c;
          r_sel   <= sel_for(r_op, 1'b0);
        end
      end
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = r_valid;
  assign O_alu_sel = r_sel;
  assign o_alu_a   = r_a[0];
  assign o_alu_b   = r_b[0];
  assign o_alu_c   = r_carry;
  assign O_result  = r_result;
  assign o_carry   = r_cout;
  assign o_zero    = r_zero;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl: behavioural 1-bit slice plus an arithmetic reference model.
module tb_bit_serial_alu_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [2:0]   I_op = 3'd0;
  logic [W-1:0] I_a = '0;
  logic [W-1:0] I_b = '0;
  logic [3:0]   O_alu_sel;
  logic         o_alu_a, o_alu_b, o_alu_c;
  logic         i_alu_s, i_alu_c;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [W-1:0] O_result;
  logic         o_carry, o_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl #(.W(W), .FUNCTION_BITS(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .I_op(I_op), .I_a(I_a), .I_b(I_b), .O_alu_sel(O_alu_sel),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_c(o_alu_c),
    .i_alu_s(i_alu_s), .i_alu_c(i_alu_c), .o_valid(o_valid), .i_ready(i_ready),
    .O_result(O_result), .o_carry(o_carry), .o_zero(o_zero)
  );

  // Behavioural 1-bit ALU slice.
  logic bb, cin, cy;
  always_comb begin
    bb = o_alu_b ^ O_alu_sel[0];
    case (O_alu_sel[2:1])
      2'b00:   cin = 1'b0;
      2'b01:   cin = 1'b1;
      2'b10:   cin = o_alu_c;
      default: cin = o_alu_b;
    endcase
    cy      = (o_alu_a & bb) | (o_alu_a & cin) | (bb & cin);
    i_alu_c = cy;
    i_alu_s = O_alu_sel[3] ? cy : (o_alu_a ^ bb ^ cin);
  end

  // Reference result: {zero, carry, result}.
  function automatic logic [W+1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c;
    case (op)
      3'd0:    t = {1'b0, a} + {1'b0, b};
      3'd1:    t = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      3'd2:    t = {1'b0, a} + (W+1)'(1);
      3'd3:    t = {1'b0, a} + {1'b0, {W{1'b1}}};
      3'd4:    t = {1'b0, a & b};
      3'd5:    t = {1'b0, a | b};
      3'd6:    t = {1'b0, a ^ b};
      default: t = {1'b0, ~(a ^ b)};
    endcase
    r = t[W-1:0];
    c = op[2] ? 1'b0 : t[W];
    return {(r == '0), c, r};
  endfunction

  // Opcode table for the slice select.
  function automatic logic [3:0] exp_sel(input logic [2:0] op, input logic first);
    case (op)
      3'd0:    return first ? 4'b0000 : 4'b0100;
      3'd1:    return first ? 4'b0011 : 4'b0101;
      3'd2:    return first ? 4'b0010 : 4'b0100;
      3'd3:    return first ? 4'b0001 : 4'b0101;
      3'd4:    return 4'b1000;
      3'd5:    return 4'b1010;
      3'd6:    return 4'b0000;
      default: return 4'b0001;
    endcase
  endfunction

  // Issue one command, follow it through RUN, take the result.
  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic c, output logic z,
                        output int lat, output int sel_bad);
    int n;
    @(negedge clk);
    I_op = op; I_a = a; I_b = b; i_valid = 1'b1;
    n = 0;
    while (o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    i_valid = 1'b0;
    lat = 0; sel_bad = 0;
    while (o_valid !== 1'b1 && lat < 4 * W) begin
      if (lat < W && O_alu_sel !== exp_sel(op, lat == 0)) sel_bad++;
      @(negedge clk);
      lat++;
    end
    res = O_result; c = o_carry; z = o_zero;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_ready); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid); else n_pass++;
    n_checks++; if (O_result !== '0) $display("FAIL reset_result got %h want 00", O_result); else n_pass++;
    n_checks++; if (o_carry !== 1'b0) $display("FAIL reset_carry got %b want 0", o_carry); else n_pass++;
    n_checks++; if (o_zero !== 1'b1) $display("FAIL reset_zero got %b want 1", o_zero); else n_pass++;
    n_checks++; if (O_alu_sel !== 4'b0) $display("FAIL reset_sel got %b want 0000", O_alu_sel); else n_pass++;
    n_checks++;
    if ({o_alu_a, o_alu_b, o_alu_c} !== 3'b000)
      $display("FAIL reset_slice_bits got %b want 000", {o_alu_a, o_alu_b, o_alu_c});
    else n_pass++;
  endtask

  task automatic test_add_boundary();
    logic [W-1:0] r; logic c, z; int lat, sb;
    do_cmd(3'd0, 8'hFF, 8'h01, r, c, z, lat, sb);
    n_checks++; if (r !== 8'h00) $display("FAIL add_ff_result got %h want 00", r); else n_pass++;
    n_checks++; if (c !== 1'b1) $display("FAIL add_ff_carry got %b want 1", c); else n_pass++;
    n_checks++; if (z !== 1'b1) $display("FAIL add_ff_zero got %b want 1", z); else n_pass++;
    n_checks++; if (lat != W) $display("FAIL add_latency got %0d want %0d", lat, W); else n_pass++;
    n_checks++; if (sb != 0) $display("FAIL add_sel got %0d bad cycles want 0", sb); else n_pass++;
  endtask

  task automatic test_sub();
    logic [W-1:0] r; logic c, z; int lat, sb;
    do_cmd(3'd1, 8'h05, 8'h07, r, c, z, lat, sb);
    n_checks++; if (r !== 8'hFE) $display("FAIL sub_neg_result got %h want fe", r); else n_pass++;
    n_checks++; if (c !== 1'b0) $display("FAIL sub_neg_carry got %b want 0", c); else n_pass++;
    n_checks++; if (z !== 1'b0) $display("FAIL sub_neg_zero got %b want 0", z); else n_pass++;
    do_cmd(3'd1, 8'h07, 8'h05, r, c, z, lat, sb);
    n_checks++; if (r !== 8'h02) $display("FAIL sub_pos_result got %h want 02", r); else n_pass++;
    n_checks++; if (c !== 1'b1) $display("FAIL sub_pos_carry got %b want 1", c); else n_pass++;
    n_checks++; if (sb != 0) $display("FAIL sub_sel got %0d bad cycles want 0", sb); else n_pass++;
  endtask

  task automatic test_logic();
    logic [W-1:0] r; logic c, z; int lat, sb;
    logic [W-1:0] want [4];
    want[0] = 8'h30; want[1] = 8'hFC; want[2] = 8'hCC; want[3] = 8'h33;
    for (int i = 0; i < 4; i++) begin
      do_cmd(3'(4 + i), 8'hF0, 8'h3C, r, c, z, lat, sb);
      n_checks++; if (r !== want[i]) $display("FAIL logic%0d_result got %h want %h", i, r, want[i]); else n_pass++;
      n_checks++; if (c !== 1'b0) $display("FAIL logic%0d_carry got %b want 0", i, c); else n_pass++;
      n_checks++; if (sb != 0) $display("FAIL logic%0d_sel_const got %0d bad cycles want 0", i, sb); else n_pass++;
    end
    n_checks++; if (O_alu_sel !== 4'b0) $display("FAIL idle_sel got %b want 0000", O_alu_sel); else n_pass++;
  endtask

  task automatic test_incdec();
    logic [W-1:0] r; logic c, z; int lat, sb;
    do_cmd(3'd2, 8'hFF, 8'hAA, r, c, z, lat, sb);
    n_checks++; if (r !== 8'h00) $display("FAIL inc_result got %h want 00", r); else n_pass++;
    n_checks++; if (c !== 1'b1) $display("FAIL inc_carry got %b want 1", c); else n_pass++;
    n_checks++; if (z !== 1'b1) $display("FAIL inc_zero got %b want 1", z); else n_pass++;
    do_cmd(3'd3, 8'h00, 8'hAA, r, c, z, lat, sb);
    n_checks++; if (r !== 8'hFF) $display("FAIL dec_result got %h want ff", r); else n_pass++;
    n_checks++; if (c !== 1'b0) $display("FAIL dec_carry got %b want 0", c); else n_pass++;
    n_checks++; if (z !== 1'b0) $display("FAIL dec_zero got %b want 0", z); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] r, a, b; logic c, z; int lat, sb;
    logic [2:0] op; logic [W+1:0] e;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      e  = ref_model(op, a, b);
      do_cmd(op, a, b, r, c, z, lat, sb);
      n_checks++;
      if ({z, c, r} !== e || lat != W || sb != 0)
        $display("FAIL rand%0d op=%0d a=%h b=%h got z%b c%b r=%h lat=%0d selbad=%0d want z%b c%b r=%h lat=%0d",
                 i, op, a, b, z, c, r, lat, sb, e[W+1], e[W], e[W-1:0], W);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] e1, e2; int n, lat;
    e1 = ref_model(3'd0, 8'h3C, 8'h11);
    e2 = ref_model(3'd1, 8'h50, 8'h20);
    @(negedge clk);
    I_op = 3'd0; I_a = 8'h3C; I_b = 8'h11; i_valid = 1'b1;
    n = 0;
    while (o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    // Next command is presented and held from here on.
    I_op = 3'd1; I_a = 8'h50; I_b = 8'h20;
    n = 0;
    while (o_valid !== 1'b1 && n < 4 * W) begin @(negedge clk); n++; end
    n_checks++; if (n != W) $display("FAIL bp_latency got %0d want %0d", n, W); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (O_result !== e1[W-1:0] || o_valid !== 1'b1 || o_ready !== 1'b0)
        $display("FAIL bp_hold%0d got r=%h v=%b rdy=%b want r=%h v=1 rdy=0", i, O_result, o_valid, o_ready, e1[W-1:0]);
      else n_pass++;
      @(negedge clk);
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL bp_after_handshake got rdy=%b v=%b want rdy=1 v=0", o_ready, o_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (o_ready !== 1'b0) $display("FAIL bp_accept got rdy=%b want 0", o_ready); else n_pass++;
    i_valid = 1'b0;
    lat = 0;
    while (o_valid !== 1'b1 && lat < 4 * W) begin @(negedge clk); lat++; end
    n_checks++;
    if ({o_zero, o_carry, O_result} !== e2 || lat != W)
      $display("FAIL bp_second got z%b c%b r=%h lat=%0d want z%b c%b r=%h lat=%0d",
               o_zero, o_carry, O_result, lat, e2[W+1], e2[W], e2[W-1:0], W);
    else n_pass++;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] r; logic c, z; int lat, sb, n, vio;
    @(negedge clk);
    I_op = 3'd0; I_a = 8'hAB; I_b = 8'h11; i_valid = 1'b1;
    n = 0;
    while (o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || O_result !== '0 || o_carry !== 1'b0 || o_zero !== 1'b1)
      $display("FAIL midrun_reset_flags got v=%b rdy=%b r=%h c=%b z=%b want v=0 rdy=1 r=00 c=0 z=1",
               o_valid, o_ready, O_result, o_carry, o_zero);
    else n_pass++;
    n_checks++;
    if (O_alu_sel !== 4'b0 || {o_alu_a, o_alu_b, o_alu_c} !== 3'b000)
      $display("FAIL midrun_reset_slice got sel=%b abc=%b want 0000 000", O_alu_sel, {o_alu_a, o_alu_b, o_alu_c});
    else n_pass++;
    vio = 0;
    repeat (2) begin @(negedge clk); if (o_valid !== 1'b0) vio++; end
    rst_n = 1'b1;
    repeat (2 * W) begin @(negedge clk); if (o_valid !== 1'b0) vio++; end
    n_checks++; if (vio != 0) $display("FAIL midrun_no_valid got %0d valid cycles want 0", vio); else n_pass++;
    do_cmd(3'd0, 8'h12, 8'h34, r, c, z, lat, sb);
    n_checks++; if (r !== 8'h46) $display("FAIL post_reset_add got %h want 46", r); else n_pass++;
    n_checks++; if (c !== 1'b0) $display("FAIL post_reset_carry got %b want 0", c); else n_pass++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add_boundary();
    test_sub();
    test_logic();
    test_incdec();
    test_backpressure();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
- Sequencer that drives the team's 1-bit ALU slice to perform a W-bit operation bit-serially, LSB first.
- Accepts a command (opcode plus two operands) over a valid/ready handshake.
- Each cycle it generates the slice function select, the operand bits and the chained carry, and collects the slice sum/carry into a result register.
- Returns the result, carry and zero flags over a second valid/ready handshake. Sits between the datapath control and one ALU slice instance.

Parameters:
- W, 8, operand/result width in bits (minimum 2).
- FUNCTION_BITS, 4, slice function-select width (fixed at 4).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  command valid.
- o_ready  output  1  command ready.
- I_op  input  3  opcode.
- I_a  input  W  operand A.
- I_b  input  W  operand B.
- O_alu_sel  output  FUNCTION_BITS  to slice I_sel.
- o_alu_a  output  1  to slice i_a.
- o_alu_b  output  1  to slice i_b.
- o_alu_c  output  1  to slice i_c.
- i_alu_s  input  1  from slice o_s.
- i_alu_c  input  1  from slice o_c.
- o_valid  output  1  result valid.
- i_ready  input  1  result accepted.
- O_result  output  W  result.
- o_carry  output  1  final carry.
- o_zero  output  1  result == 0.

Behaviour:
- Slice select encoding:
  - sel[0]: invert b.
  - sel[2:1]: carry-in source; 00=0, 01=1, 10=i_c, 11=i_b.
  - sel[3]: output carry instead of sum.
- Opcodes, giving bit-0 select / bits 1..W-1 select / B source:
  - 000 ADD: 0000 / 0100 / I_b.
  - 001 SUB: 0011 / 0101 / I_b. o_carry = NOT borrow.
  - 010 INC: 0010 / 0100 / B forced 0.
  - 011 DEC: 0001 / 0101 / B forced 0.
  - 100 AND: 1000 every bit.
  - 101 OR: 1010 every bit.
  - 110 XOR: 0000 every bit.
  - 111 XNOR: 0001 every bit.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - o_ready=1.
  - When i_valid&&o_ready: latch I_op, I_a and (I_b or 0) into shift registers; clear the bit counter and the carry register; go to RUN.
- RUN (exactly W cycles, bit index k = 0..W-1):
  - Drive o_alu_a = A[k] and o_alu_b = B[k] (LSB of the shift registers), O_alu_sel per opcode/k, and o_alu_c = carry register.
  - On each edge: shift i_alu_s into the result MSB (right shift) and capture i_alu_c into the carry register.
  - After k=W-1, go to DONE.
- DONE:
  - o_valid=1; O_result, o_carry and o_zero are stable.
  - o_carry = last i_alu_c for ADD/SUB/INC/DEC, and 0 for logic ops.
  - On i_valid... not accepted here; on i_ready go to IDLE.
- Handshakes:
  - o_ready is 1 only in IDLE; commands presented in RUN or DONE are not accepted and must be held by the source.
  - The result is held unchanged while o_valid && !i_ready (unbounded backpressure).
  - No bypass from DONE to RUN: an accept occurs at the earliest the cycle after the result handshake.
- Latency: accept at edge T; o_valid rises after edge T+W; throughput is one op per W+2 cycles at best.
- Outside RUN: O_alu_sel=0, o_alu_a=o_alu_b=o_alu_c=0.
- Reset (any time, including mid-RUN):
  - State goes to IDLE; o_valid=0, o_ready=1 after release.
  - O_result=0, o_carry=0, o_zero=1, counter=0, carry register=0.
  - A partially computed operation is discarded with no result.
- Unused opcode bits: none; all 8 codes are defined.

Test Plan:
- ADD, W=8, A=0xFF, B=0x01 -> O_result=0x00, o_carry=1, o_zero=1; o_valid rises exactly 8 cycles after accept.
- SUB, A=0x05, B=0x07 -> 0xFE, o_carry=0, o_zero=0. SUB, A=0x07, B=0x05 -> 0x02, o_carry=1.
- Logic: A=0xF0, B=0x3C. AND -> 0x30; OR -> 0xFC; XOR -> 0xCC; XNOR -> 0x33. All with o_carry=0. Also check O_alu_sel is constant over all 8 RUN cycles.
- INC A=0xFF -> 0x00, carry 1, zero 1. DEC A=0x00 -> 0xFF, carry 0 (B input ignored, drive B=0xAA).
- Backpressure: hold i_ready=0 for 5 cycles in DONE with i_valid=1 and a new command -> result stable, o_ready=0, new command not accepted until the cycle after i_ready=1.
- Assert i_rst_n=0 at RUN bit 3 of an ADD -> outputs go immediately to their reset values with no o_valid pulse. A fresh ADD 0x12+0x34 afterwards -> 0x46, carry 0.
